// File: rtl/dc_track_pkg.sv
// Shared types and width helpers for the time-shared DC tracker.
package dc_track_pkg;

    typedef enum logic {
        IDLE  = 1'b0,
        SWEEP = 1'b1
    } state_t;

    function automatic int cw_of(input int n);
        return (n > 1) ? $clog2(n) : 1;
    endfunction

    function automatic int cnt_w(input int div, input int iir);
        return div - iir;
    endfunction

    function automatic int step_w(input int n);
        return n + 1;
    endfunction

    function automatic int lsb(input int c, input int w);
        return c * w;
    endfunction

endpackage

// File: rtl/dc_track_scheduler_dc_step.sv
// One DC-tracking step: rounded 1/2^IIR IIR move toward the sample,
// with a +/-1 nudge so the estimate never stalls short of the sample.
module dc_step
    import dc_track_pkg::*;
#(
    parameter int N   = 18,
    parameter int IIR = 8
) (
    input  logic [N-1:0] sample,
    input  logic [N-1:0] dc,
    output logic [N-1:0] dc_next
);

    localparam int W = step_w(N);

    logic signed [W-1:0] inc;
    logic signed [W-1:0] step;
    logic        [N-1:0] delta;

    // The move is bounded by |sample - dc|, so N-bit wrap-around add is exact.
    always_comb begin
        inc   = $signed({sample[N-1], sample}) - $signed({dc[N-1], dc});
        step  = (inc >>> IIR) + $signed(W'(inc[IIR-1]));
        delta = '0;
        if (step != '0)
            delta = step[N-1:0];
        else if (inc[W-1])
            delta = '1;
        else if (inc != '0)
            delta = N'(1);
        dc_next = dc + delta;
    end

endmodule

// File: rtl/dc_track_scheduler.sv
// Periodic sweep that updates each channel's DC estimate through one
// shared step unit; control logic may preset any channel while idle.
module dc_track_scheduler
    import dc_track_pkg::*;
#(
    parameter  int N        = 18,
    parameter  int CHANNELS = 4,
    parameter  int DIV      = 20,
    parameter  int IIR      = 8,
    localparam int CW       = cw_of(CHANNELS)
) (
    input  logic                  Clk,
    input  logic                  Reset,
    input  logic [CHANNELS*N-1:0] Input,
    input  logic [CHANNELS-1:0]   Enable,
    input  logic                  PresetValid,
    input  logic [CW-1:0]         PresetChannel,
    input  logic [N-1:0]          PresetValue,
    output logic                  PresetReady,
    output logic [CHANNELS*N-1:0] DC,
    output logic [CHANNELS-1:0]   Updated,
    output logic                  Busy
);

    localparam int            CTW  = cnt_w(DIV, IIR);
    localparam logic [CW-1:0] LAST = CW'(CHANNELS - 1);
    localparam logic [CW:0]   NCH  = (CW + 1)'(CHANNELS);

    state_t               state;
    state_t               state_nxt;
    logic [CTW-1:0]       count;
    logic [CW-1:0]        ch;
    logic [N-1:0]         s_q  [CHANNELS];
    logic [N-1:0]         dc_q [CHANNELS];
    logic [CHANNELS-1:0]  upd_q;
    logic [N-1:0]         dc_next;
    logic                 tick;
    logic                 last;
    logic                 preset_ok;

    assign tick      = (count == '0);
    assign last      = (ch == LAST);
    assign preset_ok = PresetValid && PresetReady
                       && ({1'b0, PresetChannel} < NCH);

    always_ff @(posedge Clk or posedge Reset) begin
        if (Reset)
            state <= IDLE;
        else
            state <= state_nxt;
    end

    always_comb begin
        state_nxt = state;
        case (state)
            IDLE:    if (tick) state_nxt = SWEEP;
            SWEEP:   if (last) state_nxt = IDLE;
            default: state_nxt = IDLE;
        endcase
    end

    always_comb begin
        PresetReady = (state == IDLE);
        Busy        = (state == SWEEP);
    end

    always_ff @(posedge Clk or posedge Reset) begin
        if (Reset)
            count <= '0;
        else
            count <= count - 1'b1;
    end

    // Presets only land in IDLE, so they never collide with a sweep write.
    always_ff @(posedge Clk or posedge Reset) begin
        if (Reset) begin
            ch    <= '0;
            upd_q <= '0;
            for (int c = 0; c < CHANNELS; c++) begin
                s_q[c]  <= '0;
                dc_q[c] <= '0;
            end
        end else begin
            upd_q <= '0;
            if (state == IDLE && tick) begin
                ch <= '0;
                for (int c = 0; c < CHANNELS; c++)
                    s_q[c] <= Input[lsb(c, N) +: N];
            end
            if (state == SWEEP) begin
                ch <= last ? '0 : ch + 1'b1;
                if (Enable[ch]) begin
                    dc_q[ch]  <= dc_next;
                    upd_q[ch] <= 1'b1;
                end
            end
            if (preset_ok) begin
                dc_q[PresetChannel]  <= PresetValue;
                upd_q[PresetChannel] <= 1'b1;
            end
        end
    end

    dc_step #(
        .N   (N),
        .IIR (IIR)
    ) u_step (
        .sample  (s_q[ch]),
        .dc      (dc_q[ch]),
        .dc_next (dc_next)
    );

    for (genvar g = 0; g < CHANNELS; g++) begin : g_dc
        assign DC[lsb(g, N) +: N] = dc_q[g];
    end

    assign Updated = upd_q;

endmodule
